// File: rtl/image_cache_loader_ring_pkg.sv
// Shared types for the image-cache ring loader: FSM state encoding and bank-index helpers.
package image_cache_loader_ring_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    // Widest legal ring is four banks.
    typedef logic [1:0] bank_idx_t;

    function automatic int bank_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/image_cache_loader_ring_addr_gen.sv
// X/Y write-position counter with runtime wrap limits, last-word flag and synchronous clear.
// IMAGE_CACHE_LOADER_SOF_EN adds the raw-origin flag used for frame-alignment checking.
module image_cache_addr_gen #(
    parameter int COL_WIDTH = 9,
    parameter int ROW_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    input  logic                 restart,
    input  logic [COL_WIDTH-1:0] x_max,
    input  logic [ROW_WIDTH-1:0] y_max,
    output logic [COL_WIDTH-1:0] x,
    output logic [ROW_WIDTH-1:0] y,
`ifdef IMAGE_CACHE_LOADER_SOF_EN
    output logic                 origin,
`endif
    output logic                 last
);

    logic [COL_WIDTH-1:0] x_q;
    logic [ROW_WIDTH-1:0] y_q;

    // A restart forces the current word to (0,0) so counting resumes from there.
    assign x    = restart ? '0 : x_q;
    assign y    = restart ? '0 : y_q;
    assign last = (x == x_max) && (y == y_max);
`ifdef IMAGE_CACHE_LOADER_SOF_EN
    assign origin = (x_q == '0) && (y_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            if (last) begin
                x_q <= '0;
                y_q <= '0;
            end else if (x == x_max) begin
                x_q <= '0;
                y_q <= y + ROW_WIDTH'(1);
            end else begin
                x_q <= x + COL_WIDTH'(1);
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/image_cache_loader_ring.sv
// Ring loader: fills NUM_BANKS cache banks from a word stream, stalling only when all are occupied.
// Optional IMAGE_CACHE_LOADER_SOF_EN adds sof/err_frame; release strobe is bank_release (release is reserved).
module image_cache_loader_ring
    import image_cache_loader_ring_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COL_WIDTH  = 9,
    parameter int ROW_WIDTH  = 9,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_WIDTH = bank_width(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COL_WIDTH:0]    cfg_width,
    input  logic [ROW_WIDTH:0]    cfg_height,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_ready,
    output logic                  data_wanted,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [COL_WIDTH-1:0]  waddrX,
    output logic [ROW_WIDTH-1:0]  waddrY,
    output logic [BANK_WIDTH-1:0] wbank,
    output logic                  loaded,
    output logic [BANK_WIDTH-1:0] loaded_bank,
    input  logic                  bank_release,
    output logic [BANK_WIDTH:0]   occupancy,
`ifdef IMAGE_CACHE_LOADER_SOF_EN
    input  logic                  sof,
    output logic                  err_frame,
`endif
    output logic                  err_underflow
);

    localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [BANK_WIDTH:0]   OCC_LAST  = (BANK_WIDTH + 1)'(NUM_BANKS - 1);

    state_t                 state, state_next;
    logic [COL_WIDTH-1:0]   w_m1;
    logic [ROW_WIDTH-1:0]   h_m1;
    logic [BANK_WIDTH-1:0]  bank;
    logic [COL_WIDTH-1:0]   x_cur;
    logic [ROW_WIDTH-1:0]   y_cur;
    logic                   last, xfer, done, rel_ok, cfg_ok, restart;

    assign cfg_ok = start && (cfg_width != '0) && (cfg_height != '0);
    assign xfer   = data_ready && data_wanted;
    assign done   = xfer && last;
    assign rel_ok = bank_release && (occupancy != '0);

`ifdef IMAGE_CACHE_LOADER_SOF_EN
    logic origin;
    assign restart = xfer && sof;
`else
    assign restart = 1'b0;
`endif

    image_cache_addr_gen #(
        .COL_WIDTH(COL_WIDTH),
        .ROW_WIDTH(ROW_WIDTH)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .advance(xfer),
        .restart(restart),
        .x_max  (w_m1),
        .y_max  (h_m1),
        .x      (x_cur),
        .y      (y_cur),
`ifdef IMAGE_CACHE_LOADER_SOF_EN
        .origin (origin),
`endif
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (cfg_ok) state_next = FILL;
            FILL: if (done && !rel_ok && occupancy == OCC_LAST) state_next = FULL;
            FULL: if (rel_ok) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_wanted = (state == FILL);
    end

    // Frame geometry is held as inclusive maxima so 2^WIDTH fits the counter width.
    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_ok) begin
            w_m1 <= cfg_width[COL_WIDTH-1:0] - COL_WIDTH'(1);
            h_m1 <= cfg_height[ROW_WIDTH-1:0] - ROW_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy     <= '0;
            bank          <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (done && !rel_ok)      occupancy <= occupancy + (BANK_WIDTH + 1)'(1);
            else if (!done && rel_ok) occupancy <= occupancy - (BANK_WIDTH + 1)'(1);
            if (done) bank <= (bank == LAST_BANK) ? '0 : bank + BANK_WIDTH'(1);
            if (bank_release && occupancy == '0) err_underflow <= 1'b1;
        end
    end

    // Write stage: one cycle after the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            we          <= 1'b0;
            wdata       <= '0;
            waddrX      <= '0;
            waddrY      <= '0;
            wbank       <= '0;
            loaded      <= 1'b0;
            loaded_bank <= '0;
        end else begin
            we     <= xfer;
            loaded <= done;
            if (xfer) begin
                wdata  <= data;
                waddrX <= x_cur;
                waddrY <= y_cur;
                wbank  <= bank;
            end
            if (done) loaded_bank <= bank;
        end
    end

`ifdef IMAGE_CACHE_LOADER_SOF_EN
    always_ff @(posedge clk) begin
        if (reset)                        err_frame <= 1'b0;
        else if (xfer && (sof != origin)) err_frame <= 1'b1;
    end
`endif

endmodule
